// File: rtl/kws_alert_ctrl.sv
// Keyword-spotting alert sequencer: confirms detections, drives tone/LED, enforces hold-off, owns the matcher threshold.
// Optional confirmed-detection counter is enabled with `define KWS_DET_COUNT_EN.
module kws_alert_ctrl #(
    parameter int CONSEC          = 2,
    parameter int BEEP_CYCLES     = 50000000,
    parameter int HOLDOFF_CYCLES  = 25000000,
    parameter int TONE_HALF       = 6250,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SCR_W           = 16,
    parameter int SCR_PRV         = 6500,
    parameter int SCR_PUB         = 4000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             result_dv,
    input  logic             result,
    input  logic             vad_in,
    input  logic             switch,
    output logic [SCR_W-1:0] scr_o,
    output logic             beep,
    output logic             led_det,
    output logic             busy,
    output logic [7:0]       det_count,
    output logic [1:0]       state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, ALERT = 2'd2, HOLDOFF = 2'd3} state_t;

    localparam int CW   = (CONSEC > 1) ? $clog2(CONSEC + 1) : 1;
    localparam int TMAX = (BEEP_CYCLES > HOLDOFF_CYCLES) ? BEEP_CYCLES : HOLDOFF_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int NW   = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [CW-1:0] CONSEC_LAST = CW'(CONSEC - 1);
    localparam logic [TW-1:0] BEEP_LAST   = TW'(BEEP_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLDOFF_CYCLES - 1);
    localparam logic [NW-1:0] TONE_LAST   = NW'(TONE_HALF - 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [NW-1:0]     tone_q, tone_d;
    logic              beep_q, beep_d;
    logic              led_q, busy_q;
    logic              sw_s1_q, sw_s2_q, sw_acc_q;
    logic [DW-1:0]     db_q;
    logic [SCR_W-1:0]  scr_q, scr_pend;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = '0;
        case (state_q)
            IDLE: begin
                if (result_dv && result) begin
                    if (CONSEC == 1) begin
                        state_d = ALERT;
                        cnt_d   = '0;
                    end else begin
                        state_d = ARM;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ARM: begin
                // Voice dropout outranks a simultaneous positive frame.
                if (!vad_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (result_dv) begin
                    if (!result) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CONSEC_LAST) begin
                        state_d = ALERT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ALERT: begin
                if (timer_q == BEEP_LAST) state_d = HOLDOFF;
                else                      timer_d = timer_q + TW'(1);
            end
            HOLDOFF: begin
                if (timer_q == HOLD_LAST) state_d = IDLE;
                else                      timer_d = timer_q + TW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Tone restarts high on every entry into ALERT and is silent elsewhere.
    always_comb begin
        beep_d = 1'b0;
        tone_d = '0;
        if (state_d == ALERT) begin
            if (state_q != ALERT) begin
                beep_d = 1'b1;
            end else if (tone_q == TONE_LAST) begin
                beep_d = ~beep_q;
            end else begin
                beep_d = beep_q;
                tone_d = tone_q + NW'(1);
            end
        end
    end

    assign scr_pend = sw_acc_q ? SCR_W'(SCR_PRV) : SCR_W'(SCR_PUB);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            timer_q  <= '0;
            tone_q   <= '0;
            beep_q   <= 1'b0;
            led_q    <= 1'b0;
            busy_q   <= 1'b0;
            sw_s1_q  <= 1'b1;
            sw_s2_q  <= 1'b1;
            sw_acc_q <= 1'b1;
            db_q     <= '0;
            scr_q    <= SCR_W'(SCR_PRV);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            tone_q  <= tone_d;
            beep_q  <= beep_d;
            led_q   <= (state_d == ALERT);
            busy_q  <= (state_d == ALERT) || (state_d == HOLDOFF);
            sw_s1_q <= switch;
            sw_s2_q <= sw_s1_q;
            if (sw_s1_q != sw_s2_q)  db_q     <= '0;
            else if (db_q == DB_LAST) sw_acc_q <= sw_s2_q;
            else                      db_q     <= db_q + DW'(1);
            // Threshold only moves between detections.
            if (state_q == IDLE) scr_q <= scr_pend;
        end
    end

`ifdef KWS_DET_COUNT_EN
    logic [7:0] det_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            det_q <= 8'd0;
        end else if ((state_q != ALERT) && (state_d == ALERT) && (det_q != 8'hFF)) begin
            det_q <= det_q + 8'd1;
        end
    end
    assign det_count = det_q;
`else
    assign det_count = 8'd0;
`endif

    assign scr_o     = scr_q;
    assign beep      = beep_q;
    assign led_det   = led_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;
endmodule
